uart_rx_engine: RTL and testbench

Receive engine for the UART with TSI: the inbound counterpart of the transmit engine. It synchronises the serial `rx` line, detects and qualifies a start bit, and samples 7 or 8 data bits, an optional parity bit and a stop bit at mid-bit. It then presents the assembled byte with ready, parity-error, framing-error and overrun flags to the processor-side interface, which acknowledges with a one-cycle `read` pulse.

---
 rtl/uart_rx_engine.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_engine
//  Description : UART receive engine. Synchronises the serial line, qualifies
//                a start bit, samples 7/8 data bits, optional parity and the
//                stop bit at mid-bit, and presents the byte with ready,
//                parity-error, framing-error and overrun flags.
//                Optional build macro UART_RX_MAJORITY_EN selects 2-of-3
//                majority sampling around each mid-bit point.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_engine #(
  parameter int BIT_TIME = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  START    = 2'd1;
  localparam logic [1:0]  DATA     = 2'd2;
  localparam logic [1:0]  STOP     = 2'd3;
  localparam logic [15:0] CNT_FULL = 16'(BIT_TIME);
  localparam logic [15:0] CNT_HALF = 16'(BIT_TIME / 2);

  logic        rx_meta;
  logic        rx_s;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic        cfg_eight;
  logic        cfg_pen;
  logic        cfg_ohel;

  logic        expire;
  logic        tick;
  logic        bit_in;
  logic [3:0]  data_bits;
  logic [3:0]  frame_bits;
  logic [7:0]  data_out;
  logic        exp_par;
  logic        stop_take;
  logic        read_ack;

  // The counter holds the cycles remaining to the next sample point; the
  // sample point is the cycle in which it reads 1.
  assign expire     = (state != IDLE) && (cnt == 16'd1);
  assign data_bits  = cfg_eight ? 4'd8 : 4'd7;
  assign frame_bits = data_bits + {3'b000, cfg_pen};
  assign data_out   = cfg_eight ? shreg : {1'b0, shreg[7:1]};
  assign exp_par    = cfg_ohel ? ~^data_out : ^data_out;
  assign stop_take  = (state == STOP) && tick;
  assign read_ack   = read & rxrdy;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj_a;
  logic maj_b;
  logic pend;

  // Capture the line one cycle before and at the sample point; the decision
  // is taken one cycle later together with the third sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
      pend  <= 1'b0;
    end else begin
      if ((state != IDLE) && (cnt == 16'd2)) maj_a <= rx_s;
      if (expire) maj_b <= rx_s;
      pend <= expire;
    end
  end

  assign tick   = pend;
  assign bit_in = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
  assign tick   = expire;
  assign bit_in = rx_s;
`endif

  // Bit-period counter: half a bit to the start sample, then full bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if ((state == IDLE) && !rx_s) begin
      cnt <= CNT_HALF;
    end else if (expire) begin
      cnt <= CNT_FULL;
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end

  // Frame sequencer: start qualification, data/parity capture, stop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      cfg_eight <= 1'b0;
      cfg_pen   <= 1'b0;
      cfg_ohel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cfg_eight <= eight;
            cfg_pen   <= pen;
            cfg_ohel  <= ohel;
            bit_cnt   <= '0;
            state     <= START;
          end
        end
        START: begin
          if (tick) state <= bit_in ? IDLE : DATA;
        end
        DATA: begin
          if (tick) begin
            // The parity bit is kept apart so a 9-bit frame never pushes
            // the first data bit out of the 8-bit shift register.
            if (bit_cnt < data_bits) shreg <= {bit_in, shreg[7:1]};
            else                     par_bit <= bit_in;
            if (bit_cnt == frame_bits - 4'd1) state <= STOP;
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        STOP: begin
          if (tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Processor-side outputs: a completed frame takes priority over read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= 8'h00;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (stop_take) begin
      rx_data <= data_out;
      rxrdy   <= 1'b1;
      ferr    <= ~bit_in;
      perr    <= cfg_pen & (par_bit != exp_par);
      if (rxrdy && !read) ovf <= 1'b1;
      else if (read_ack)  ovf <= 1'b0;
    end else if (read_ack) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_engine
//  Description : Self-checking bench for uart_rx_engine with a frame-level
//                reference model (byte, parity rule, overrun bookkeeping).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_engine;

  localparam int BT = 16;
  localparam int HB = BT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk;
  logic       reset;
  logic       rx;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       read;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int checks;
  int failures;

  // Reference model state
  logic [7:0] m_data;
  logic       m_rxrdy, m_perr, m_ferr, m_ovf;

  logic [11:0] obs;
  assign obs = {rx_data, rxrdy, perr, ferr, ovf};

  uart_rx_engine #(.BIT_TIME(BT)) dut (
    .clk(clk), .reset(reset), .rx(rx), .eight(eight), .pen(pen), .ohel(ohel),
    .read(read), .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr), .ferr(ferr),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] model_vec();
    return {m_data, m_rxrdy, m_perr, m_ferr, m_ovf};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rxrdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    if (m_rxrdy) begin
      m_rxrdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
    end
  endtask

  // Drive one frame on the line and record what the receiver must report.
  // flip inverts the correct parity bit; rd_upd means a read coincides with
  // the frame's output update.
  task automatic send_frame(input logic [7:0] d, input logic e, input logic p,
                            input logic o, input logic flip, input logic stop,
                            input logic rd_upd);
    int nd;
    int ones;
    logic par;
    logic bits[$];
    nd   = e ? 8 : 7;
    ones = 0;
    for (int i = 0; i < nd; i++) ones += int'(d[i]);
    // Even sense: total ones including parity is even; odd sense: odd
    par = (o ? ((ones + 1) % 2) : (ones % 2)) != 0;
    par = par ^ flip;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(d[i]);
    if (p) bits.push_back(par);
    bits.push_back(stop);
    eight = e; pen = p; ohel = o;
    foreach (bits[i]) begin
      rx = bits[i];
      if (i == 1) begin
        eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
      end
      repeat (BT) @(negedge clk);
    end
    rx = 1'b1;
    m_data = e ? d : {1'b0, d[6:0]};
    m_ferr = !stop;
    m_perr = p & flip;
    if (rd_upd)       m_ovf = 0;
    else if (m_rxrdy) m_ovf = 1;
    m_rxrdy = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1; read = 0; eight = 1; pen = 0; ohel = 0;
    model_reset();
    idle(3);
    checks++;
    if (obs !== 12'h000) begin
      failures++;
      $display("FAIL reset_hold: got %h want %h (data,rdy/perr/ferr/ovf)", obs, 12'h000);
    end
    reset = 1'b1;
    idle(5);
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1, 0, 0, 0, 1, 0);
    idle(2);
    checks++;
    if (obs !== {8'hA5, 4'b1000}) begin
      failures++;
      $display("FAIL basic_a5: got %h want %h", obs, {8'hA5, 4'b1000});
    end
    pulse_read();
    checks++;
    if (obs !== {8'hA5, 4'b0000}) begin
      failures++;
      $display("FAIL basic_read: got %h want %h", obs, {8'hA5, 4'b0000});
    end
    pulse_read();
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL read_idle: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_parity();
    send_frame(8'h41, 0, 1, 0, 1, 1, 0);
    idle(2);
    checks++;
    if (rx_data !== 8'h41 || perr !== 1'b1 || obs !== model_vec()) begin
      failures++;
      $display("FAIL parity_bad: got %h want %h", obs, {8'h41, 4'b1100});
    end
    pulse_read();
    send_frame(8'h41, 0, 1, 0, 0, 1, 0);
    idle(2);
    checks++;
    if (obs !== {8'h41, 4'b1000}) begin
      failures++;
      $display("FAIL parity_good: got %h want %h", obs, {8'h41, 4'b1000});
    end
    pulse_read();
    send_frame(8'hC8, 1, 1, 1, 1, 1, 0);
    idle(2);
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL parity_odd8: got %h want %h", obs, model_vec());
    end
    pulse_read();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1, 0, 0, 0, 0, 0);
    idle(2);
    checks++;
    if (obs !== {8'h3C, 4'b1010}) begin
      failures++;
      $display("FAIL framing_err: got %h want %h", obs, {8'h3C, 4'b1010});
    end
    idle(2 * BT);
    pulse_read();
    send_frame(8'h55, 1, 0, 0, 0, 1, 0);
    idle(2);
    checks++;
    if (obs !== {8'h55, 4'b1000}) begin
      failures++;
      $display("FAIL framing_clear: got %h want %h", obs, {8'h55, 4'b1000});
    end
    pulse_read();
  endtask

  task automatic test_back_to_back();
    int k;
    send_frame(8'h11, 1, 0, 0, 0, 1, 0);
    send_frame(8'h22, 1, 0, 0, 0, 1, 0);
    idle(2);
    checks++;
    if (obs !== {8'h22, 4'b1001}) begin
      failures++;
      $display("FAIL overrun: got %h want %h", obs, {8'h22, 4'b1001});
    end
    pulse_read();
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL overrun_read: got %h want %h", obs, model_vec());
    end
    // Second pass: read lands exactly on the edge of the second update
    k = 2 + HB + 9 * BT + EXTRA;
    send_frame(8'h11, 1, 0, 0, 0, 1, 0);
    fork
      send_frame(8'h22, 1, 0, 0, 0, 1, 1);
      begin
        repeat (k) @(negedge clk);
        checks++;
        if (rx_data !== 8'h11 || rxrdy !== 1'b1) begin
          failures++;
          $display("FAIL pre_update: got %h want %h", obs, {8'h11, 4'b1000});
        end
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        checks++;
        if (obs !== {8'h22, 4'b1000}) begin
          failures++;
          $display("FAIL read_on_update: got %h want %h", obs, {8'h22, 4'b1000});
        end
      end
    join
    idle(2);
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL after_update: got %h want %h", obs, model_vec());
    end
    pulse_read();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * BT);
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL glitch_flags: got %h want %h", obs, model_vec());
    end
    send_frame(8'h96, 1, 0, 0, 0, 1, 0);
    idle(2);
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL glitch_next: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    rx = 1'b0; idle(BT);
    rx = 1'b1; idle(BT);
    rx = 1'b0; idle(4);
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== 12'h000) begin
      failures++;
      $display("FAIL reset_async: got %h want %h", obs, 12'h000);
    end
    @(negedge clk);
    rx = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(BT);
    send_frame(8'hC3, 1, 0, 0, 0, 1, 0);
    idle(2);
    checks++;
    if (obs !== {8'hC3, 4'b1000}) begin
      failures++;
      $display("FAIL reset_recover: got %h want %h", obs, {8'hC3, 4'b1000});
    end
    pulse_read();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic e, p, o, flip, stop;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      e    = 1'($urandom);
      p    = 1'($urandom);
      o    = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, e, p, o, flip, stop, 0);
      idle(2);
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("FAIL random_frame%0d: got %h want %h", n, obs, model_vec());
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        checks++;
        if (obs !== model_vec()) begin
          failures++;
          $display("FAIL random_read%0d: got %h want %h", n, obs, model_vec());
        end
      end
      if (!stop) idle(2 * BT);
      else       idle($urandom_range(0, BT));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
